// File: rtl/serial_unsigned_subtractor_pkg.sv
// Shared helpers for the serial unsigned subtractor.
package serial_unsigned_subtractor_pkg;

  // Width of a counter that can hold every value from 0 to width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_unsigned_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow is produced when b exceeds a, or when a equals b and a borrow arrives.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_unsigned_subtractor.sv
// Bit-serial unsigned subtractor: computes (A - B - BI) mod 2^WIDTH one bit
// per clock, LSB first, and reports the final borrow.
module serial_unsigned_subtractor
  import serial_unsigned_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bo;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_capture;
  logic             w_last;

  // The single per-bit arithmetic cell works on the current LSBs.
  full_subtractor u_full_subtractor (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Next-state logic; also flags operand capture and the final bit step.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_next = ST_RUN;
          w_capture    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = ST_FIN;
          w_last       = 1'b1;
        end
      end
      ST_FIN: begin
        if (START) begin
          w_state_next = ST_RUN;
          w_capture    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset wins over any request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture operands, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bo     <= 1'b0;
    end else if (w_capture) begin
      r_a      <= A;
      r_b      <= B;
      r_acc    <= '0;
      r_borrow <= BI;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      r_acc    <= {w_d, r_acc[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff <= {w_d, r_acc[WIDTH-1:1]};
        r_bo   <= w_bout;
      end
    end
  end

  assign BUSY = (r_state == ST_RUN);
  assign DONE = (r_state == ST_FIN);
  assign DIFF = r_diff;
  assign BO   = r_bo;

endmodule

// File: tb/tb_serial_unsigned_subtractor.sv
// Self-checking bench for serial_unsigned_subtractor (WIDTH = 8).
module tb_serial_unsigned_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       bi_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bo;

  int n_pass  = 0;
  int n_total = 0;

  serial_unsigned_subtractor #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .A     (a_in),
    .B     (b_in),
    .BI    (bi_in),
    .BUSY  (busy),
    .DONE  (done),
    .DIFF  (diff),
    .BO    (bo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain modular subtraction and a magnitude compare.
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int av, bv;
    av = int'(a);
    bv = int'(b) + int'(bi);
    ref_sub[7:0] = 8'((av - bv) & 255);
    ref_sub[8]   = (av < bv);
  endfunction

  // Launch one operation and follow it to its DONE pulse (bounded).
  // Inputs are scrambled after the capture edge; results must not care.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic o_bo,
                       output int lat, output int busy_n, output bit held);
    logic [7:0] d_prev;
    logic       bo_prev;
    @(negedge clk);
    d_prev  = diff;
    bo_prev = bo;
    a_in = a; b_in = b; bi_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    bi_in = 1'($urandom);
    lat = 0; busy_n = 0; held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (diff !== d_prev || bo !== bo_prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    d    = diff;
    o_bo = bo;
  endtask

  vec_t       vecs[6];
  logic [7:0] d_got;
  logic       bo_got;
  logic [8:0] exp_r;
  int         lat, busy_n, cnt, done_seen;
  bit         held;

  initial begin
    vecs[0] = '{"5-3",      8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{"0-1",      8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{"0-0-bi",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"80-7F-bi", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{"FF-FF-bi", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{"C3-3C",    8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bi_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo",   bo,   0);
    rst = 1'b0;

    // Directed vectors: result, latency, BUSY width, hold during RUN, single-cycle DONE.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bi, d_got, bo_got, lat, busy_n, held);
      $display("vec %s: A=%h B=%h BI=%0d -> DIFF=%h BO=%0d lat=%0d", vecs[i].name,
               vecs[i].a, vecs[i].b, vecs[i].bi, d_got, bo_got, lat);
      chk({vecs[i].name, "_diff"}, d_got, vecs[i].diff);
      chk({vecs[i].name, "_bo"},   bo_got, vecs[i].bo);
      chk({vecs[i].name, "_lat"},  lat, 8);
      chk({vecs[i].name, "_busy"}, busy_n, 8);
      chk({vecs[i].name, "_hold"}, held, 1);
      chk({vecs[i].name, "_finbusy"}, busy, 0);
      @(negedge clk);
      chk({vecs[i].name, "_done1"}, done, 0);
      chk({vecs[i].name, "_idle"},  busy, 0);
    end

    // START during RUN cycle 3 with a new operand must be ignored.
    @(negedge clk);
    a_in = 8'h10; b_in = 8'h01; bi_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a_in = 8'h00;
    @(negedge clk); start = 1'b0;
    cnt = 3;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    $display("ignore-start: DIFF=%h BO=%0d lat=%0d", diff, bo, cnt);
    chk("ign_lat",  cnt,  8);
    chk("ign_diff", diff, 8'h0F);
    chk("ign_bo",   bo,   0);
    @(negedge clk);
    chk("ign_idle", busy, 0);

    // Reset during RUN cycle 4 aborts with no DONE.
    @(negedge clk);
    a_in = 8'h55; b_in = 8'h22; bi_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("abort: BUSY=%0d DONE=%0d DIFF=%h BO=%0d", busy, done, diff, bo);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bo",   bo,   0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_nodone", done_seen, 0);

    // START held high: second op starts from FIN with no idle cycle, so the
    // pulses sit 9 indices apart with exactly 8 non-DONE cycles between them.
    begin
      int         first, second;
      logic [7:0] d1, d2;
      logic       b1, b2;
      first = -1; second = -1; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
      @(negedge clk);
      a_in = 8'h30; b_in = 8'h05; bi_in = 1'b0; start = 1'b1;
      @(negedge clk);
      a_in = 8'h07; b_in = 8'h09; bi_in = 1'b1;
      for (int k = 0; k < 40 && second < 0; k++) begin
        if (done) begin
          chk("b2b_finbusy", busy, 0);
          if (first < 0) begin
            first = k; d1 = diff; b1 = bo;
          end else begin
            second = k; d2 = diff; b2 = bo; start = 1'b0;
          end
        end
        if (second < 0) @(negedge clk);
      end
      $display("b2b: first=%0d second=%0d d1=%h/%0d d2=%h/%0d", first, second, d1, b1, d2, b2);
      chk("b2b_first",  first, 8);
      chk("b2b_gap",    second - first, 9);
      chk("b2b_d1",     d1, 8'h2B);
      chk("b2b_b1",     b1, 0);
      chk("b2b_d2",     d2, 8'hFD);
      chk("b2b_b2",     b2, 1);
      @(negedge clk);
      chk("b2b_idle",   busy | done, 0);
    end

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rbi;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom_range(1, 0));
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      exp_r = ref_sub(ra, rb, rbi);
      do_op(ra, rb, rbi, d_got, bo_got, lat, busy_n, held);
      $display("rnd %0d: A=%h B=%h BI=%0d -> DIFF=%h BO=%0d (exp %h/%0d)", i, ra, rb, rbi,
               d_got, bo_got, exp_r[7:0], exp_r[8]);
      chk("rnd_diff", d_got, exp_r[7:0]);
      chk("rnd_bo",   bo_got, exp_r[8]);
      chk("rnd_lat",  lat, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_unsigned_subtractor.md
SERIAL_UNSIGNED_SUBTRACTOR -- requirements
Module: serial_unsigned_subtractor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned minuend.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned subtrahend.
REQ-007 The block SHALL have port BI, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking DIFF/BO as newly valid.
REQ-010 The block SHALL have port DIFF, output, WIDTH bits: registered result (A - B - BI) mod 2^WIDTH.
REQ-011 The block SHALL have port BO, output, 1 bit: registered borrow-out, 1 iff A < B + BI.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-013 In IDLE or FIN with START=1 at an edge, the block SHALL capture A, B and BI into internal shift registers, clear the bit counter and enter RUN.
REQ-014 In IDLE with START=0 the block SHALL stay in IDLE; in FIN with START=0 it SHALL return to IDLE.
REQ-015 Each RUN edge SHALL process exactly one bit, LSB first: d = a ^ b ^ borrow, borrow_next = (~a & b) | (~(a ^ b) & borrow); BI is the initial borrow.
REQ-016 After the WIDTH-th RUN edge the block SHALL enter FIN, load DIFF with the assembled difference and BO with the final borrow.
REQ-017 DONE SHALL be 1 exactly in FIN, i.e. asserted WIDTH cycles after the START capture edge, for one cycle.
REQ-018 BUSY SHALL be 1 exactly in RUN; it SHALL be 0 in IDLE and FIN.
REQ-019 START SHALL be ignored while in RUN; captured operands SHALL be unaffected by changes on A, B or BI after capture.
REQ-020 DIFF and BO SHALL change only on the edge entering FIN and SHALL hold between operations, including during RUN.
REQ-021 START asserted in FIN SHALL begin a new operation back-to-back with no idle cycle.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH with no width extension beyond the single borrow bit.

Reset
REQ-023 RST=1 at an edge SHALL force IDLE, BUSY=0, DONE=0, DIFF=0 and BO=0, and clear the counter and shift registers.
REQ-024 RST SHALL take priority over START and SHALL abort an operation in RUN with no DONE pulse.

Structure
REQ-025 State encodings SHALL be local constants in the module; no shared package is required.
REQ-026 The per-bit logic SHALL be one sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-027 The counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-028 The bench SHALL check: A=8'h05, B=8'h03, BI=0, START pulse -> BUSY for 8 cycles, then DONE pulse with DIFF=8'h02, BO=0.
REQ-029 The bench SHALL check: A=8'h00, B=8'h01, BI=0 -> DIFF=8'hFF, BO=1; and A=8'h00, B=8'h00, BI=1 -> DIFF=8'hFF, BO=1.
REQ-030 The bench SHALL check: A=8'h80, B=8'h7F, BI=1 -> DIFF=8'h00, BO=0; and A=8'hFF, B=8'hFF, BI=1 -> DIFF=8'hFF, BO=1.
REQ-031 The bench SHALL check: START with A=8'h10, B=8'h01, then START with A=8'h00 at RUN cycle 3 -> second request ignored, DIFF=8'h0F, BO=0.
REQ-032 The bench SHALL check: RST at RUN cycle 4 -> next cycle IDLE, all outputs 0, no DONE pulse.
REQ-033 The bench SHALL check: START held high through FIN -> second operation starts immediately, DONE pulses exactly 8 cycles apart.
